// File: rtl/pressure_abnormality_monitor.sv
// ============================================================================
// Module   : pressure_abnormality_monitor
// Purpose  : Parity-checked pressure sample stream, range check, and a
//            persistence-gated latched alarm. Optional build macro:
//            PRESSURE_AUTO_CLEAR_EN (self-clearing alarm after recovery).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pressure_abnormality_monitor #(
   parameter int DATA_W  = 6,
   parameter int LOW_TH  = 4,
   parameter int HIGH_TH = 27,
   parameter int PERSIST = 3,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] pressure_data,
   input  logic              alarm_ack,
   output logic              abnormal_now,
   output logic              parity_error,
   output logic              pressure_alarm,
   output logic [CNT_W-1:0]  parity_err_count,
   output logic [1:0]        state_dbg
);

   localparam int VAL_W  = DATA_W - 1;
   localparam int PCNT_W = $clog2(PERSIST + 1);

   localparam logic [VAL_W-1:0]  c_LOW_TH  = VAL_W'(LOW_TH);
   localparam logic [VAL_W-1:0]  c_HIGH_TH = VAL_W'(HIGH_TH);
   localparam logic [PCNT_W-1:0] c_PERSIST = PCNT_W'(PERSIST);
   localparam logic [CNT_W-1:0]  c_CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_NORMAL  = 2'd0,
      ST_PENDING = 2'd1,
      ST_ALARM   = 2'd2
   } state_t;

   state_t            r_state;
   logic [PCNT_W-1:0] r_persist_cnt;
   logic [CNT_W-1:0]  r_err_cnt;
   logic              r_abnormal;
   logic              r_parity_error;
   logic              r_alarm;
`ifdef PRESSURE_AUTO_CLEAR_EN
   logic [PCNT_W-1:0] r_recover_cnt;
`endif

   logic              w_par_err;
   logic              w_good;
   logic              w_abn;
   logic [VAL_W-1:0]  w_value;

   // Even parity over the whole word, parity bit included.
   assign w_par_err = ^pressure_data;
   assign w_good    = sample_valid & ~w_par_err;
   assign w_value   = pressure_data[VAL_W-1:0];
   assign w_abn     = (w_value < c_LOW_TH) | (w_value > c_HIGH_TH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= ST_NORMAL;
         r_persist_cnt  <= '0;
         r_err_cnt      <= '0;
         r_abnormal     <= 1'b0;
         r_parity_error <= 1'b0;
         r_alarm        <= 1'b0;
`ifdef PRESSURE_AUTO_CLEAR_EN
         r_recover_cnt  <= '0;
`endif
      end else begin
         r_parity_error <= sample_valid & w_par_err;
         if (sample_valid && w_par_err && (r_err_cnt != c_CNT_MAX))
            r_err_cnt <= r_err_cnt + 1'b1;
         if (w_good)
            r_abnormal <= w_abn;

         case (r_state)
            ST_PENDING: begin
               if (w_good) begin
                  if (w_abn) begin
                     r_persist_cnt <= r_persist_cnt + 1'b1;
                     if (r_persist_cnt + 1'b1 == c_PERSIST) begin
                        r_state <= ST_ALARM;
                        r_alarm <= 1'b1;
                     end
                  end else begin
                     r_persist_cnt <= '0;
                     r_state       <= ST_NORMAL;
                  end
               end
            end
            ST_ALARM: begin
               // Acknowledge takes priority over any sample in the same cycle.
               if (alarm_ack) begin
                  r_state       <= ST_NORMAL;
                  r_persist_cnt <= '0;
                  r_alarm       <= 1'b0;
`ifdef PRESSURE_AUTO_CLEAR_EN
                  r_recover_cnt <= '0;
               end else if (w_good) begin
                  if (w_abn) begin
                     r_recover_cnt <= '0;
                  end else if (r_recover_cnt + 1'b1 == c_PERSIST) begin
                     r_state       <= ST_NORMAL;
                     r_persist_cnt <= '0;
                     r_alarm       <= 1'b0;
                     r_recover_cnt <= '0;
                  end else begin
                     r_recover_cnt <= r_recover_cnt + 1'b1;
                  end
`endif
               end
            end
            default: begin
               // NORMAL, and the unused code 3 which behaves as NORMAL.
               if (w_good && w_abn) begin
                  r_persist_cnt <= PCNT_W'(1);
                  if (PERSIST == 1) begin
                     r_state <= ST_ALARM;
                     r_alarm <= 1'b1;
                  end else begin
                     r_state <= ST_PENDING;
                  end
               end
            end
         endcase
      end
   end

   assign abnormal_now     = r_abnormal;
   assign parity_error     = r_parity_error;
   assign pressure_alarm   = r_alarm;
   assign parity_err_count = r_err_cnt;
   assign state_dbg        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pressure_abnormality_monitor.sv
// ============================================================================
// Module   : tb_pressure_abnormality_monitor
// Purpose  : Directed self-checking bench for pressure_abnormality_monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pressure_abnormality_monitor;

   localparam int DATA_W = 6;
   localparam int CNT_W  = 8;

   logic              clk;
   logic              rst_n;
   logic              sample_valid;
   logic [DATA_W-1:0] pressure_data;
   logic              alarm_ack;
   logic              abnormal_now;
   logic              parity_error;
   logic              pressure_alarm;
   logic [CNT_W-1:0]  parity_err_count;
   logic [1:0]        state_dbg;

   int checks = 0;
   int errors = 0;

   pressure_abnormality_monitor #(
      .DATA_W (DATA_W),
      .LOW_TH (4),
      .HIGH_TH(27),
      .PERSIST(3),
      .CNT_W  (CNT_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sample_valid    (sample_valid),
      .pressure_data   (pressure_data),
      .alarm_ack       (alarm_ack),
      .abnormal_now    (abnormal_now),
      .parity_error    (parity_error),
      .pressure_alarm  (pressure_alarm),
      .parity_err_count(parity_err_count),
      .state_dbg       (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Good sample: parity bit chosen so the whole word has even parity.
   function automatic logic [DATA_W-1:0] good(input int v);
      logic [DATA_W-2:0] x;
      x = v[DATA_W-2:0];
      return {^x, x};
   endfunction

   task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic a);
      @(negedge clk);
      sample_valid  = v;
      pressure_data = d;
      alarm_ack     = a;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      drive(1'b1, 6'b000001, 1'b0);
      drive(1'b1, good(30), 1'b0);
      drive(1'b1, good(30), 1'b0);
      drive(1'b1, good(30), 1'b0);
      checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL rst_pre_alarm state got %0d exp 2", state_dbg); end
      @(negedge clk);
      rst_n = 1'b0; sample_valid = 1'b1; pressure_data = good(31); alarm_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_dbg); end
      checks++; if (pressure_alarm !== 1'b0) begin errors++; $display("FAIL rst_alarm got %0b exp 0", pressure_alarm); end
      checks++; if (abnormal_now !== 1'b0) begin errors++; $display("FAIL rst_abnormal got %0b exp 0", abnormal_now); end
      checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL rst_parity got %0b exp 0", parity_error); end
      checks++; if (parity_err_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", parity_err_count); end
      @(negedge clk);
      rst_n = 1'b1; sample_valid = 1'b0;
   endtask

   task automatic test_persistence;
      drive(1'b1, good(30), 1'b0);
      checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL pers_s1 got %0d exp 1", state_dbg); end
      checks++; if (abnormal_now !== 1'b1) begin errors++; $display("FAIL pers_abn got %0b exp 1", abnormal_now); end
      drive(1'b0, good(15), 1'b0);
      checks++; if (abnormal_now !== 1'b1) begin errors++; $display("FAIL pers_idle_abn got %0b exp 1", abnormal_now); end
      drive(1'b1, good(30), 1'b0);
      checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL pers_s2 got %0d exp 1", state_dbg); end
      checks++; if (pressure_alarm !== 1'b0) begin errors++; $display("FAIL pers_noalarm got %0b exp 0", pressure_alarm); end
      drive(1'b1, good(30), 1'b0);
      checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL pers_s3 got %0d exp 2", state_dbg); end
      checks++; if (pressure_alarm !== 1'b1) begin errors++; $display("FAIL pers_alarm got %0b exp 1", pressure_alarm); end
      drive(1'b0, good(30), 1'b1);
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL pers_ack got %0d exp 0", state_dbg); end
      drive(1'b1, good(30), 1'b0);
      drive(1'b1, good(30), 1'b0);
      drive(1'b1, good(15), 1'b0);
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL pers_break got %0d exp 0", state_dbg); end
      checks++; if (pressure_alarm !== 1'b0) begin errors++; $display("FAIL pers_break_alarm got %0b exp 0", pressure_alarm); end
      checks++; if (abnormal_now !== 1'b0) begin errors++; $display("FAIL pers_break_abn got %0b exp 0", abnormal_now); end
   endtask

   task automatic test_parity;
      drive(1'b1, 6'b000001, 1'b0);
      checks++; if (parity_error !== 1'b1) begin errors++; $display("FAIL par_pulse got %0b exp 1", parity_error); end
      checks++; if (parity_err_count !== 8'd1) begin errors++; $display("FAIL par_count got %0d exp 1", parity_err_count); end
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL par_state got %0d exp 0", state_dbg); end
      drive(1'b0, 6'b000001, 1'b0);
      checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL par_pulse_end got %0b exp 0", parity_error); end
      drive(1'b1, good(30), 1'b0);
      drive(1'b1, 6'b000001, 1'b0);
      checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL par_mid_state got %0d exp 1", state_dbg); end
      checks++; if (abnormal_now !== 1'b1) begin errors++; $display("FAIL par_mid_abn got %0b exp 1", abnormal_now); end
      drive(1'b1, good(30), 1'b0);
      drive(1'b1, 6'b100000, 1'b0);
      drive(1'b1, good(30), 1'b0);
      checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL par_persist got %0d exp 2", state_dbg); end
      checks++; if (parity_err_count !== 8'd3) begin errors++; $display("FAIL par_count3 got %0d exp 3", parity_err_count); end
      drive(1'b0, good(30), 1'b1);
      for (int i = 0; i < 300; i++) drive(1'b1, 6'b000111, 1'b0);
      checks++; if (parity_err_count !== 8'd255) begin errors++; $display("FAIL par_saturate got %0d exp 255", parity_err_count); end
      drive(1'b0, 6'b000111, 1'b0);
   endtask

   task automatic test_thresholds;
      drive(1'b1, good(4), 1'b0);
      checks++; if (abnormal_now !== 1'b0) begin errors++; $display("FAIL th_4 got %0b exp 0", abnormal_now); end
      drive(1'b1, good(3), 1'b0);
      checks++; if (abnormal_now !== 1'b1) begin errors++; $display("FAIL th_3 got %0b exp 1", abnormal_now); end
      drive(1'b1, good(27), 1'b0);
      checks++; if (abnormal_now !== 1'b0) begin errors++; $display("FAIL th_27 got %0b exp 0", abnormal_now); end
      drive(1'b1, good(28), 1'b0);
      checks++; if (abnormal_now !== 1'b1) begin errors++; $display("FAIL th_28 got %0b exp 1", abnormal_now); end
      drive(1'b1, good(15), 1'b0);
   endtask

   task automatic test_ack;
      drive(1'b1, good(30), 1'b1);
      checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL ack_normal got %0d exp 1", state_dbg); end
      drive(1'b1, good(30), 1'b0);
      drive(1'b1, good(30), 1'b0);
      checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL ack_pre got %0d exp 2", state_dbg); end
      drive(1'b1, good(31), 1'b1);
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL ack_win got %0d exp 0", state_dbg); end
      checks++; if (pressure_alarm !== 1'b0) begin errors++; $display("FAIL ack_alarm got %0b exp 0", pressure_alarm); end
      drive(1'b1, good(30), 1'b0);
      drive(1'b1, good(30), 1'b0);
      checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL ack_recount got %0d exp 1", state_dbg); end
      drive(1'b1, good(30), 1'b0);
      checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL ack_realarm got %0d exp 2", state_dbg); end
      drive(1'b0, good(30), 1'b1);
   endtask

   task automatic test_auto_clear;
      drive(1'b1, good(30), 1'b0);
      drive(1'b1, good(30), 1'b0);
      drive(1'b1, good(30), 1'b0);
      drive(1'b1, good(15), 1'b0);
      drive(1'b1, good(15), 1'b0);
      drive(1'b1, good(31), 1'b0);
      drive(1'b1, good(15), 1'b0);
      checks++; if (pressure_alarm !== 1'b1) begin errors++; $display("FAIL ac_pattern got %0b exp 1", pressure_alarm); end
      drive(1'b1, 6'b000001, 1'b0);
      drive(1'b1, good(15), 1'b0);
      checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL ac_hold got %0d exp 2", state_dbg); end
      drive(1'b1, good(15), 1'b0);
`ifdef PRESSURE_AUTO_CLEAR_EN
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL ac_clear got %0d exp 0", state_dbg); end
      checks++; if (pressure_alarm !== 1'b0) begin errors++; $display("FAIL ac_clear_alarm got %0b exp 0", pressure_alarm); end
`else
      checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL ac_noclear got %0d exp 2", state_dbg); end
      checks++; if (pressure_alarm !== 1'b1) begin errors++; $display("FAIL ac_noclear_alarm got %0b exp 1", pressure_alarm); end
`endif
      drive(1'b0, good(15), 1'b1);
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL ac_final got %0d exp 0", state_dbg); end
   endtask

   initial begin
      rst_n = 1'b0; sample_valid = 1'b0; pressure_data = '0; alarm_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_reset();
      test_persistence();
      test_parity();
      test_thresholds();
      test_ack();
      test_auto_clear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
